// File: rtl/hash_store_sequencer.sv
// Streams a captured digest to word-addressed memory, one word per accepted write.
// Word order, byte swap and geometry are parameters; abort cancels, done pulses at the end.
module hash_store_sequencer #(
  parameter int WORD_W     = 32,
  parameter int NUM_WORDS  = 8,
  parameter int ADDR_W     = 8,
  parameter int WORD_ORDER = 1,
  parameter int BYTE_SWAP  = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [WORD_W*NUM_WORDS-1:0]        hash_vector,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic                               h_ready,
  output logic                               h_write,
  output logic [WORD_W-1:0]                  h_data,
  output logic [ADDR_W-1:0]                  h_addr,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_WORDS+1)-1:0]     words_done
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(NUM_WORDS+1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic [WORD_W*NUM_WORDS-1:0]   shadow, shadow_nxt;
  logic                          h_write_nxt, busy_nxt, done_nxt;
  logic [WORD_W-1:0]             h_data_nxt;
  logic [ADDR_W-1:0]             h_addr_nxt;
  logic [CNT_W-1:0]              words_done_nxt;
  logic                          xfer;

  function automatic logic [WORD_W-1:0] pick_word(input logic [WORD_W*NUM_WORDS-1:0] vec,
                                                  input int k);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] s;
    if (WORD_ORDER != 0) w = vec[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
    else                 w = vec[k*WORD_W +: WORD_W];
    s = w;
    if (BYTE_SWAP != 0)
      for (int b = 0; b < WORD_W/8; b++) s[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
    return s;
  endfunction

  assign xfer = h_write && h_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      shadow     <= '0;
      h_write    <= 1'b0;
      h_data     <= '0;
      h_addr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      h_write    <= h_write_nxt;
      h_data     <= h_data_nxt;
      h_addr     <= h_addr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      words_done <= words_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    shadow_nxt     = shadow;
    h_write_nxt    = h_write;
    h_data_nxt     = h_data;
    h_addr_nxt     = h_addr;
    done_nxt       = 1'b0;
    words_done_nxt = words_done;
    case (state)
      S_IDLE: begin
        // word 0 comes straight from the input since the shadow loads on this same edge
        if (start) begin
          state_nxt      = S_WRITE;
          shadow_nxt     = hash_vector;
          idx_nxt        = '0;
          words_done_nxt = '0;
          h_write_nxt    = 1'b1;
          h_data_nxt     = pick_word(hash_vector, 0);
          h_addr_nxt     = base_addr;
        end
      end
      S_WRITE: begin
        if (xfer) words_done_nxt = words_done + CNT_W'(1);
        if (abort) begin
          state_nxt   = S_IDLE;
          h_write_nxt = 1'b0;
        end else if (xfer) begin
          if (idx == IDX_W'(NUM_WORDS-1)) begin
            state_nxt   = S_DONE;
            h_write_nxt = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            idx_nxt    = idx + IDX_W'(1);
            h_data_nxt = pick_word(shadow, int'(idx) + 1);
            h_addr_nxt = h_addr + ADDR_W'(1);
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_hash_store_sequencer.sv
// Two instances (MS-first plain, LS-first byte-swapped) driven in lockstep and scored
// against a list-of-writes model derived from the captured digest and base address.
module tb_hash_store_sequencer;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] hash_vector = '0;
  logic [7:0]   base_addr = '0;
  logic         h_ready = 1'b0;

  logic        h_write_a, busy_a, done_a, h_write_b, busy_b, done_b;
  logic [31:0] h_data_a, h_data_b;
  logic [7:0]  h_addr_a, h_addr_b;
  logic [3:0]  words_done_a, words_done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0, done_cyc = 0;
  logic [39:0] qa[$], qb[$];
  int          qc[$];
  bit          stall_a = 0, stall_b = 0;
  logic [39:0] hold_a, hold_b;

  hash_store_sequencer #(.WORD_W(32), .NUM_WORDS(8), .ADDR_W(8), .WORD_ORDER(1), .BYTE_SWAP(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .hash_vector(hash_vector),
    .base_addr(base_addr), .h_ready(h_ready), .h_write(h_write_a), .h_data(h_data_a),
    .h_addr(h_addr_a), .busy(busy_a), .done(done_a), .words_done(words_done_a));

  hash_store_sequencer #(.WORD_W(32), .NUM_WORDS(8), .ADDR_W(8), .WORD_ORDER(0), .BYTE_SWAP(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .hash_vector(hash_vector),
    .base_addr(base_addr), .h_ready(h_ready), .h_write(h_write_b), .h_data(h_data_b),
    .h_addr(h_addr_b), .busy(busy_b), .done(done_b), .words_done(words_done_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected write k: address base+k mod 256, data per word order / byte swap.
  function automatic logic [39:0] exp_a(input logic [255:0] v, input logic [7:0] base, input int k);
    logic [7:0] a;
    a = base + 8'(k);
    return {a, v[(7-k)*32 +: 32]};
  endfunction

  function automatic logic [39:0] exp_b(input logic [255:0] v, input logic [7:0] base, input int k);
    logic [7:0]  a;
    logic [31:0] w;
    a = base + 8'(k);
    w = v[k*32 +: 32];
    return {a, w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (stall_a) chk_val("stall_hold_a", {23'd0, h_write_a, h_addr_a, h_data_a}, {23'd0, 1'b1, hold_a});
      if (stall_b) chk_val("stall_hold_b", {23'd0, h_write_b, h_addr_b, h_data_b}, {23'd0, 1'b1, hold_b});
      if (h_write_a && h_ready) begin qa.push_back({h_addr_a, h_data_a}); qc.push_back(cyc); end
      if (h_write_b && h_ready) qb.push_back({h_addr_b, h_data_b});
      if (done_a) begin done_cnt_a++; done_cyc = cyc; chk_val("busy_in_done", 64'(busy_a), 64'd1); end
      if (done_b) done_cnt_b++;
    end
    stall_a = !reset && !abort && h_write_a && !h_ready;
    stall_b = !reset && !abort && h_write_b && !h_ready;
    hold_a  = {h_addr_a, h_data_a};
    hold_b  = {h_addr_b, h_data_b};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic store(input logic [255:0] vec, input logic [7:0] base, input int mode,
                       input int abort_at, input bit poke);
    int s, n_exp;
    bit aborted;
    qa.delete(); qb.delete(); qc.delete();
    done_cnt_a = 0; done_cnt_b = 0; aborted = 0;
    hash_vector = vec; base_addr = base; start = 1'b1; h_ready = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    if (poke) hash_vector = ~vec;
    for (int c = 0; c < 200 && done_cnt_a == 0 && !aborted; c++) begin
      case (mode)
        0: h_ready = 1'b1;
        1: h_ready = (c % 4 == 0) || (c % 4 == 3);
        default: h_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin start = 1'($urandom_range(0, 1)); hash_vector = rand_vec(); end
      if (abort_at >= 0 && qa.size() == abort_at) begin
        abort = 1'b1; h_ready = 1'b0;
        tick();
        abort = 1'b0; aborted = 1;
        chk_val("abort_hwrite_a", 64'(h_write_a), 64'd0);
        chk_val("abort_hwrite_b", 64'(h_write_b), 64'd0);
        chk_val("abort_words_done", 64'(words_done_a), 64'(abort_at));
      end else begin
        tick();
      end
    end
    start = 1'b0;
    if (done_cnt_a == 0 && !aborted) chk_val("store_timeout", 64'd0, 64'd1);
    tick(); tick(); tick();
    n_exp = aborted ? abort_at : 8;
    chk_val("done_count_a", 64'(done_cnt_a), aborted ? 64'd0 : 64'd1);
    chk_val("done_count_b", 64'(done_cnt_b), aborted ? 64'd0 : 64'd1);
    chk_val("xfer_count_a", 64'(qa.size()), 64'(n_exp));
    chk_val("xfer_count_b", 64'(qb.size()), 64'(n_exp));
    chk_val("words_done_a", 64'(words_done_a), 64'(n_exp));
    chk_val("words_done_b", 64'(words_done_b), 64'(n_exp));
    chk_val("idle_busy", 64'({busy_a, busy_b, h_write_a, h_write_b}), 64'd0);
    for (int k = 0; k < n_exp && k < qa.size(); k++) chk_val("word_a", 64'(qa[k]), 64'(exp_a(vec, base, k)));
    for (int k = 0; k < n_exp && k < qb.size(); k++) chk_val("word_b", 64'(qb[k]), 64'(exp_b(vec, base, k)));
    if (mode == 0 && !aborted && qc.size() == 8) begin
      chk_val("first_word_cycle", 64'(qc[0] - s), 64'd0);
      chk_val("last_word_cycle", 64'(qc[7] - s), 64'd7);
      chk_val("done_cycle", 64'(done_cyc - s), 64'd8);
    end
  endtask

  initial begin
    logic [255:0] v;
    logic [7:0]   rb;
    reset = 1'b1;
    tick(); tick();
    chk_val("reset_outs_a", {h_write_a, busy_a, done_a, words_done_a, h_addr_a, h_data_a}, 64'd0);
    chk_val("reset_outs_b", {h_write_b, busy_b, done_b, words_done_b, h_addr_b, h_data_b}, 64'd0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) v[(7-k)*32 +: 32] = 32'(k + 1);
    store(v, 8'h10, 0, -1, 0);
    if (qa.size() > 0) chk_val("t1_first", 64'(qa[0]), 64'h10_0000_0001);
    store(v, 8'h10, 1, -1, 0);

    v = rand_vec();
    store(v, 8'hFE, 0, -1, 0);
    if (qa.size() > 2) chk_val("t3_wrap_addr", 64'(qa[2][39:32]), 64'h00);

    v = rand_vec(); rb = 8'($urandom);
    store(v, rb, 0, 3, 0);
    v = rand_vec();
    store(v, 8'h40, 2, -1, 0);

    v = rand_vec(); rb = 8'($urandom);
    store(v, rb, 2, -1, 1);

    for (int i = 0; i < 4; i++) begin
      v = rand_vec(); rb = 8'($urandom);
      store(v, rb, 2, -1, 0);
    end

    v = rand_vec(); v[31:0] = 32'h11223344;
    store(v, 8'h20, 0, -1, 0);
    if (qb.size() > 0) chk_val("t6_bswap_first", 64'(qb[0][31:0]), 64'h44332211);

    // reset in the middle of a store
    qa.delete(); qb.delete(); done_cnt_a = 0; done_cnt_b = 0;
    hash_vector = rand_vec(); base_addr = 8'h30; h_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_val("midreset_a", {h_write_a, busy_a, done_a, words_done_a, h_addr_a, h_data_a}, 64'd0);
    chk_val("midreset_b", {h_write_b, busy_b, done_b, words_done_b, h_addr_b, h_data_b}, 64'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk_val("midreset_nodone", 64'(done_cnt_a + done_cnt_b), 64'd0);
    chk_val("midreset_quiet", 64'({h_write_a, h_write_b, busy_a, busy_b}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
